// File: rtl/divisor_prog.sv
// -----------------------------------------------------------------------------
// divisor_prog -- programmable clock divider with a glitch-free divisor update
//
// A W-bit counter runs from 0 to div-1 while en=1. At the terminal count (TC),
// the counter wraps to 0 and clkout toggles, so clkout has a period of 2*div
// clkin cycles with exactly 50% duty.
//
// Divisor changes are requested with load/div_in. While counting, a request is
// parked in a shadow register (pending=1) and is only applied at the next TC,
// so the current clkout half-period is never cut short. When the counter is
// stopped (en=0), or when the request arrives exactly at TC, the new divisor
// is applied on that same edge. A request of 0 is treated as 1.
//
// Configuration macro:
//   DIVISOR_TICK_EN  when defined, tick is a registered one-cycle strobe in
//                    the cycle after every TC edge. When undefined, tick is
//                    tied to 0 and no tick register is built.
//
// Parameters:
//   W        counter/divisor width in bits (2..32)
//   CNT_RST  divisor loaded at reset (1..2^W-1)
//
// Ports:
//   clkin    in   sole clock, rising edge
//   rstn     in   synchronous active-low reset
//   en       in   count enable
//   load     in   divisor change request, div_in sampled when high
//   div_in   in   requested divisor (W bits)
//   ack      out  one-cycle pulse after the edge where a new divisor took effect
//   pending  out  a captured divisor is waiting for the next TC
//   clkout   out  divided clock
//   tick     out  one-cycle strobe after each TC (see DIVISOR_TICK_EN)
// -----------------------------------------------------------------------------
module divisor_prog #(
    parameter int unsigned W       = 16,
    parameter int unsigned CNT_RST = 50000
) (
    input  logic         clkin,
    input  logic         rstn,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] div_in,
    output logic         ack,
    output logic         pending,
    output logic         clkout,
    output logic         tick
);

    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] DIV_RST = W'(CNT_RST);

    // Architectural state
    logic [W-1:0] cnt_q, cnt_d;     // position inside the current half-period
    logic [W-1:0] div_q, div_d;     // active divisor
    logic [W-1:0] shd_q, shd_d;     // shadow divisor waiting for TC
    logic         pend_q, pend_d;   // shadow holds an unapplied request
    logic         clk_q, clk_d;     // divided clock
    logic         ack_q, ack_d;     // divisor-applied strobe

    logic [W-1:0] din_sat;          // requested divisor with 0 mapped to 1
    logic         tc;               // counter is on its last count

    // A divisor of 0 would make TC unreachable; clamp it to the fastest rate.
    assign din_sat = (div_in == '0) ? ONE : div_in;

    // div_q is never 0 (reset value and every captured value are >= 1), so
    // div_q - 1 never wraps.
    assign tc = (cnt_q == (div_q - ONE));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        ack_d  = 1'b0;

        if (en) begin
            if (tc) begin
                // End of a half-period: wrap and toggle regardless of any
                // divisor change, which keeps the duty cycle at 50%.
                cnt_d = '0;
                clk_d = ~clk_q;
                if (load) begin
                    // Request lands exactly on TC: use it directly, it also
                    // supersedes anything still waiting in the shadow.
                    div_d  = din_sat;
                    pend_d = 1'b0;
                    ack_d  = 1'b1;
                end else if (pend_q) begin
                    div_d  = shd_q;
                    pend_d = 1'b0;
                    ack_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + ONE;
                if (load) begin
                    // Mid-period request: park it; a later one overwrites it.
                    shd_d  = din_sat;
                    pend_d = 1'b1;
                end
            end
        end else begin
            // Counter stopped: there is no half-period to protect, so apply
            // the newest request right away and restart the count from 0.
            // The restart also guarantees cnt stays below a smaller divisor.
            if (load) begin
                div_d  = din_sat;
                cnt_d  = '0;
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end else if (pend_q) begin
                div_d  = shd_q;
                cnt_d  = '0;
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            cnt_q  <= '0;
            div_q  <= DIV_RST;
            shd_q  <= DIV_RST;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            ack_q  <= ack_d;
        end
    end

    assign ack     = ack_q;
    assign pending = pend_q;
    assign clkout  = clk_q;

    // -------------------------------------------------------------------------
    // Optional terminal-count strobe
    // -------------------------------------------------------------------------
`ifdef DIVISOR_TICK_EN
    logic tick_q;

    // Same edge that toggles clkout, so tick is high in the cycle after TC.
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= en & tc;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

endmodule
